// File: rtl/int_adder_seq.sv
// int_adder_seq: clocked round-robin sequencer that shares one asynchronous
// dual-rail (QDI) int_adder among N_REQ synchronous requesters. It encodes
// binary operands to dual-rail, runs the four-phase handshake, then decodes
// the sum. Only one operation is in flight at a time.
// Optional watchdog: define INT_ADDER_SEQ_WDOG_EN to enable the TIMEOUT
// counter and the sticky err flag. Without it err is tied low.
module int_adder_seq #(
  parameter int WIDTH   = 32,
  parameter int N_REQ   = 4,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]         req_cin,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  input  logic                     ack_o,
  output logic [WIDTH-1:0][1:0]    a,
  output logic [WIDTH-1:0][1:0]    b,
  output logic [1:0]               c_in,
  input  logic [WIDTH-1:0][1:0]    s,
  input  logic [1:0]               c_out,
  output logic                     ack_i,
  output logic                     err
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL} state_t;
  state_t state_reg, state_next;

  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  id_reg;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic             do_grant, do_capture, do_release;
  logic             freeze;

  // Completion detection on the raw (asynchronous) adder outputs.
  // 2'b11 is not a valid code, so XOR of the rails marks a completed bit.
  logic [WIDTH-1:0] bit_valid, bit_any, sum_dec;
  logic             out_full_raw, out_empty_raw;

  // Operand selection and dual-rail encoding (1 -> 2'b10, 0 -> 2'b01).
  logic [WIDTH-1:0]      op_a [N_REQ];
  logic [WIDTH-1:0]      op_b [N_REQ];
  logic [WIDTH-1:0]      sel_a, sel_b;
  logic                  sel_cin;
  logic [WIDTH-1:0][1:0] enc_a, enc_b;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bit_valid[gi] = s[gi][1] ^ s[gi][0];
      assign bit_any[gi]   = s[gi][1] | s[gi][0];
      assign sum_dec[gi]   = s[gi][1];
      assign enc_a[gi]     = {sel_a[gi], ~sel_a[gi]};
      assign enc_b[gi]     = {sel_b[gi], ~sel_b[gi]};
    end
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
      assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign out_full_raw  = (&bit_valid) & (c_out[1] ^ c_out[0]);
  assign out_empty_raw = ~(|bit_any) & ~(|c_out);
  assign sel_a         = op_a[grant_id];
  assign sel_b         = op_b[grant_id];
  assign sel_cin       = req_cin[grant_id];

  // Synchronisers for the asynchronous handshake and completion flags.
  logic [SYNC-1:0] ack_sync_reg, full_sync_reg, empty_sync_reg;
  logic            ack_s, full_s, empty_s;

  assign ack_s   = ack_sync_reg[SYNC-1];
  assign full_s  = full_sync_reg[SYNC-1];
  assign empty_s = empty_sync_reg[SYNC-1];

  // Shift the async flags through SYNC flops before the FSM looks at them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync_reg   <= '0;
      full_sync_reg  <= '0;
      empty_sync_reg <= '0;
    end else begin
      ack_sync_reg   <= {ack_sync_reg[SYNC-2:0], ack_o};
      full_sync_reg  <= {full_sync_reg[SYNC-2:0], out_full_raw};
      empty_sync_reg <= {empty_sync_reg[SYNC-2:0], out_empty_raw};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Round-robin pick, next-state decode and handshake strobes.
  always_comb begin
    state_next  = state_reg;
    req_ready   = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    do_grant    = 1'b0;
    do_capture  = 1'b0;
    do_release  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int cand;
      cand = (int'(ptr_reg) + k) % N_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(cand);
      end
    end
    case (state_reg)
      S_IDLE: begin
        // The cycle carrying rsp_valid never grants, so a new grant lands
        // at the earliest one cycle after the result strobe.
        if (grant_found && !rsp_valid) begin
          req_ready[grant_id] = 1'b1;
          do_grant            = 1'b1;
          state_next          = S_DATA;
        end
      end
      S_DATA: begin
        if (!freeze && ack_s && full_s) begin
          do_capture = 1'b1;
          state_next = S_NULL;
        end
      end
      S_NULL: begin
        if (!freeze && !ack_s && empty_s) begin
          do_release = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: latch the granted operands, capture the sum, return to spacer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      id_reg    <= '0;
      a         <= '0;
      b         <= '0;
      c_in      <= 2'b00;
      ack_i     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (do_grant) begin
        ptr_reg <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
        id_reg  <= grant_id;
        a       <= enc_a;
        b       <= enc_b;
        c_in    <= {sel_cin, ~sel_cin};
      end
      if (do_capture) begin
        rsp_sum  <= sum_dec;
        rsp_cout <= c_out[1];
        a        <= '0;
        b        <= '0;
        c_in     <= 2'b00;
        ack_i    <= 1'b1;
      end
      if (do_release) begin
        ack_i     <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_id    <= id_reg;
      end
    end
  end

`ifdef INT_ADDER_SEQ_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);
  logic [CNT_W-1:0] wdog_cnt_reg;
  logic             err_reg;
  logic             timeout_hit;

  assign timeout_hit = (state_reg != S_IDLE) && !err_reg &&
                       (wdog_cnt_reg == CNT_W'(TIMEOUT-1));
  assign freeze      = err_reg | timeout_hit;
  assign err         = err_reg;

  // Watchdog: restart on every state change, count while waiting on the adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_next != state_reg)
        wdog_cnt_reg <= '0;
      else if (state_reg != S_IDLE && !err_reg)
        wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      if (timeout_hit)
        err_reg <= 1'b1;
    end
  end
`else
  assign freeze = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_int_adder_seq.sv
// tb_int_adder_seq: directed bench for int_adder_seq with a behavioural
// dual-rail adder (random 1-20 ns delays) and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_int_adder_seq;
  localparam int WIDTH   = 32;
  localparam int N_REQ   = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a, req_b;
  logic [N_REQ-1:0]       req_cin;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic [WIDTH-1:0]       rsp_sum;
  logic                   rsp_cout;
  logic                   ack_o;
  logic [WIDTH-1:0][1:0]  a, b, s;
  logic [1:0]             c_in, c_out;
  logic                   ack_i;
  logic                   err;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_seen = 0;
  logic stuck = 1'b0;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        cout;
  } exp_t;
  exp_t sb_q[$];
  int   exp_order[$];

  logic [31:0] vec_a [N_REQ];
  logic [31:0] vec_b [N_REQ];
  logic        vec_cin [N_REQ];
  logic [31:0] vec_sum [N_REQ];
  logic        vec_cout [N_REQ];

  always #5 clk = ~clk;

  int_adder_seq #(.WIDTH(WIDTH), .N_REQ(N_REQ), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .ack_o(ack_o), .a(a), .b(b), .c_in(c_in), .s(s), .c_out(c_out),
    .ack_i(ack_i), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic dr_full(input logic [WIDTH-1:0][1:0] v);
    for (int i = 0; i < WIDTH; i++)
      if (v[i][1] == v[i][0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] dr_val(input logic [WIDTH-1:0][1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[i][1];
    return r;
  endfunction

  // Behavioural QDI adder, polled every 1 ns on a half-ns offset from clk.
  initial begin
    int phase;
    int cnt;
    logic [32:0] r;
    phase = 0; cnt = 0;
    s = '0; c_out = 2'b00; ack_o = 1'b0;
    #0.5;
    forever begin
      #1;
      if (rst) begin
        s = '0; c_out = 2'b00; ack_o = 1'b0; phase = 0;
      end else begin
        case (phase)
          0: if (!stuck && !ack_i && dr_full(a) && dr_full(b) && (c_in[1] ^ c_in[0])) begin
               cnt = $urandom_range(20, 1); phase = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 r = {1'b0, dr_val(a)} + {1'b0, dr_val(b)} + {32'd0, c_in[1]};
                 for (int i = 0; i < WIDTH; i++) s[i] = {r[i], ~r[i]};
                 c_out = {r[32], ~r[32]};
                 ack_o = 1'b1;
                 phase = 2;
               end
             end
          2: if (ack_i && a == '0 && b == '0 && c_in == 2'b00) begin
               cnt = $urandom_range(20, 1); phase = 3;
             end
          3: begin
               cnt--;
               if (cnt == 0) begin
                 s = '0; c_out = 2'b00; ack_o = 1'b0; phase = 0;
               end
             end
          default: phase = 0;
        endcase
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      rsp_seen++;
      $display("rsp id=%0d sum=0x%08h cout=%0b", rsp_id, rsp_sum, rsp_cout);
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_sum", rsp_sum, e.sum);
        chk("rsp_cout", rsp_cout, e.cout);
        chk("ack_i_low_at_rsp", ack_i, 1'b0);
      end
    end
  end

  task automatic set_vec(input int i, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input logic [31:0] es, input logic ec);
    vec_a[i] = va; vec_b[i] = vb; vec_cin[i] = vc; vec_sum[i] = es; vec_cout[i] = ec;
  endtask

  // Raise the requesters in mask, hold each until its req_ready, and push the
  // expected result of the requester that should be granted next.
  task automatic issue(input logic [N_REQ-1:0] mask);
    logic [N_REQ-1:0] pending;
    int budget;
    int want;
    exp_t e;
    pending = mask;
    budget  = 0;
    @(posedge clk); #1;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = vec_a[i];
      req_b[i*WIDTH +: WIDTH] = vec_b[i];
      req_cin[i]              = vec_cin[i];
    end
    req_valid = pending;
    while (pending != 0 && budget < 3000) begin
      @(negedge clk);
      if (req_ready != 0) begin
        chk("ready_onehot", {63'd0, $onehot(req_ready)}, 64'd1);
        if (exp_order.size() == 0) begin
          chk("extra_grant", {60'd0, req_ready}, 64'd0);
        end else begin
          want = exp_order.pop_front();
          chk("grant_order", {60'd0, req_ready}, 64'd1 << want);
          e.id = want; e.sum = vec_sum[want]; e.cout = vec_cout[want];
          sb_q.push_back(e);
        end
        pending = pending & ~req_ready;
      end
      @(posedge clk); #1;
      req_valid = pending;
      budget++;
    end
    if (pending != 0) begin
      chk("grant_timeout", {60'd0, pending}, 64'd0);
      req_valid = '0;
    end
  endtask

  task automatic drain();
    int bud;
    bud = 0;
    while (sb_q.size() != 0 && bud < 5000) begin
      @(negedge clk);
      bud++;
    end
    if (sb_q.size() != 0) begin
      chk("rsp_timeout", sb_q.size(), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_sum"}, rsp_sum, 0);
    chk({tag, "_rsp_cout"}, rsp_cout, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_a_spacer"}, a, 0);
    chk({tag, "_b_spacer"}, b, 0);
    chk({tag, "_cin_spacer"}, c_in, 0);
    chk({tag, "_ack_i"}, ack_i, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int bud;
    int seen;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;

    // 1. reset values
    #100;
    reset_checks("reset");
    @(negedge clk); rst = 1'b0;

    // 2. single request from requester 0
    set_vec(0, 32'hFFFF_FFF6, 32'd20, 1'b1, 32'h0000_000B, 1'b1);
    exp_order = '{0}; issue(4'b0001); drain();
    repeat (3) @(negedge clk);
    chk("rsp_sum_hold", rsp_sum, 32'h0000_000B);
    chk("ack_i_idle", ack_i, 0);

    // 3. requester 2, two back-to-back operations
    set_vec(2, 32'd12, 32'd15, 1'b1, 32'h0000_001C, 1'b0);
    exp_order = '{2}; issue(4'b0100); drain();
    set_vec(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    exp_order = '{2}; issue(4'b0100); drain();

    // 4. all four at once from ptr=0, twice (pointer wraps back to 0)
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    set_vec(0, 32'd1,         32'd2,         1'b0, 32'h0000_0003, 1'b0);
    set_vec(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
    set_vec(2, 32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0);
    set_vec(3, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0);
    exp_order = '{0, 1, 2, 3}; issue(4'b1111); drain();
    set_vec(0, 32'hFFFF_FFFF, 32'd0,         1'b1, 32'h0000_0000, 1'b1);
    set_vec(1, 32'h0000_FFFF, 32'd1,         1'b0, 32'h0001_0000, 1'b0);
    set_vec(2, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0);
    set_vec(3, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1);
    exp_order = '{0, 1, 2, 3}; issue(4'b1111); drain();

    // 5. reset while in NULL abandons the operation
    set_vec(0, 32'd5, 32'd6, 1'b0, 32'd11, 1'b0);
    exp_order = '{0}; issue(4'b0001);
    bud = 0;
    while (ack_i !== 1'b1 && bud < 500) begin
      @(negedge clk);
      bud++;
    end
    chk("reached_null", ack_i, 1);
    seen = rsp_seen;
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_a_spacer", a, 0);
    chk("midrst_b_spacer", b, 0);
    chk("midrst_cin_spacer", c_in, 0);
    chk("midrst_ack_i", ack_i, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    #30;
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_rsp_abandoned", rsp_seen, seen);
    set_vec(0, 32'd100, 32'd200, 1'b1, 32'h0000_012D, 1'b0);
    exp_order = '{0}; issue(4'b0001); drain();

`ifdef INT_ADDER_SEQ_WDOG_EN
    // 6. watchdog with the adder never acknowledging
    stuck = 1'b1;
    seen  = rsp_seen;
    set_vec(1, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0);
    exp_order = '{1}; issue(4'b0010);
    repeat (TIMEOUT-1) @(posedge clk);
    #1 chk("err_before_timeout", err, 0);
    @(posedge clk);
    #1 chk("err_at_timeout", err, 1);
    req_valid = 4'b0001;
    repeat (10) @(negedge clk);
    chk("err_sticky", err, 1);
    chk("frozen_req_ready", req_ready, 0);
    chk("wdog_no_rsp", rsp_seen, seen);
    req_valid = '0;
    rst = 1'b1;
    sb_q.delete();
    #20;
    chk("err_cleared", err, 0);
    @(negedge clk); rst = 1'b0;
    stuck = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
